// File: rtl/riscv_pkg.sv
// Shared fetch-side types and constants for the instruction prefetch buffer.
package riscv_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_STEP = 4;

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_WAIT,
        FS_DISCARD
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_prefetch_buffer_if.sv
// Memory read handshake and core-facing instruction stream of the prefetch buffer.
interface instr_prefetch_buffer_if;
    import riscv_pkg::*;

    logic               mem_req_o;
    logic [XLEN-1:0]    mem_addr_o;
    logic               mem_ack_i;
    logic [INSTR_W-1:0] mem_data_i;
    logic               instr_valid_o;
    logic [INSTR_W-1:0] instr_o;
    logic [XLEN-1:0]    instr_pc_o;
    logic               instr_ready_i;

    modport master (
        output mem_req_o, mem_addr_o, instr_valid_o, instr_o, instr_pc_o,
        input  mem_ack_i, mem_data_i, instr_ready_i
    );

    modport slave (
        input  mem_req_o, mem_addr_o, instr_valid_o, instr_o, instr_pc_o,
        output mem_ack_i, mem_data_i, instr_ready_i
    );

endinterface

// File: rtl/instr_prefetch_buffer_fifo.sv
// Synchronous {pc, instr} FIFO with clear; head is a combinational read of the read slot.
module prefetch_fifo
    import riscv_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output fetch_entry_t     head
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~clear;
    assign do_pop  = pop & ~clear & (count != '0);
    assign head    = mem[rd_ptr];

    // Clear wins over push/pop; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/instr_prefetch_buffer.sv
// Sequential instruction prefetcher: one outstanding memory read, FIFO of fetched words,
// redirect flush with stale-response discard.
module instr_prefetch_buffer
    import riscv_pkg::*;
#(
    parameter  int unsigned     DEPTH    = 4,
    parameter  logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    localparam int unsigned     CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     redirect_i,
    input  logic [XLEN-1:0]          redirect_pc_i,
    instr_prefetch_buffer_if.master  bus,
    output logic [CNT_W-1:0]         count_o
);

    fetch_state_e    state;
    fetch_state_e    state_nxt;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] fetch_pc_nxt;
    logic            mem_req_nxt;
    logic [XLEN-1:0] mem_addr_nxt;
    logic            push;
    logic            pop;
    logic            clear;
    logic            fifo_has_room;
    fetch_entry_t    push_data;
    fetch_entry_t    head;

    assign fifo_has_room     = count_o < CNT_W'(DEPTH);
    assign bus.instr_valid_o = (count_o != '0);
    assign bus.instr_o       = head.instr;
    assign bus.instr_pc_o    = head.pc;
    assign push_data         = '{pc: fetch_pc, instr: bus.mem_data_i};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= FS_IDLE;
            fetch_pc       <= RESET_PC;
            bus.mem_req_o  <= 1'b0;
            bus.mem_addr_o <= RESET_PC;
        end else begin
            state          <= state_nxt;
            fetch_pc       <= fetch_pc_nxt;
            bus.mem_req_o  <= mem_req_nxt;
            bus.mem_addr_o <= mem_addr_nxt;
        end
    end

    // Redirect overrides push/pop; an unacked request rides out in DISCARD.
    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        mem_req_nxt  = bus.mem_req_o;
        mem_addr_nxt = bus.mem_addr_o;
        push         = 1'b0;
        pop          = bus.instr_valid_o & bus.instr_ready_i & ~redirect_i;
        clear        = redirect_i;

        if (redirect_i) begin
            fetch_pc_nxt = align_pc(redirect_pc_i);
        end

        case (state)
            FS_IDLE: begin
                if (!redirect_i && fifo_has_room) begin
                    state_nxt    = FS_WAIT;
                    mem_req_nxt  = 1'b1;
                    mem_addr_nxt = fetch_pc;
                end
            end
            FS_WAIT: begin
                if (bus.mem_ack_i) begin
                    state_nxt   = FS_IDLE;
                    mem_req_nxt = 1'b0;
                    if (!redirect_i) begin
                        push         = 1'b1;
                        fetch_pc_nxt = fetch_pc + XLEN'(PC_STEP);
                    end
                end else if (redirect_i) begin
                    state_nxt = FS_DISCARD;
                end
            end
            FS_DISCARD: begin
                if (bus.mem_ack_i) begin
                    state_nxt   = FS_IDLE;
                    mem_req_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt   = FS_IDLE;
                mem_req_nxt = 1'b0;
            end
        endcase
    end

    prefetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .clear     (clear),
        .count     (count_o),
        .head      (head)
    );

endmodule
